gon_pe_fifo: RTL and testbench

- Per-PE receive buffer directly downstream of the GON multicast controller (MCC).
- Captures words the MCC forwards (MCC enable_out / data_out) into a first-word-fall-through FIFO.
- Returns ready to the MCC's ready_in (ready = not full).
- Drains toward the PE datapath with a valid/ready handshake, decoupling bus delivery from PE consumption.

---
 rtl/gon_pkg.sv | 14 +
 rtl/gon_pe_fifo_if.sv | 31 +++
 rtl/gon_fifo_mem.sv | 24 ++
 rtl/gon_pe_fifo.sv | 101 ++++++++++
 tb/tb_gon_pe_fifo.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/gon_pkg.sv
// Shared GON payload types and sizing helpers for the per-PE receive path.
package gon_pkg;

  localparam int GON_DATA_WIDTH = 64;
  localparam int GON_TAG_WIDTH  = 4;

  typedef logic [GON_DATA_WIDTH-1:0] gon_word_t;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int gon_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage : gon_pkg

// File: rtl/gon_pe_fifo_if.sv
// Bus between the MCC/PE side (master) and the per-PE receive FIFO (slave).
interface gon_pe_fifo_if
  import gon_pkg::*;
#(
  parameter int DATA_WIDTH = GON_DATA_WIDTH,
  parameter int DEPTH      = 4
);

  localparam int CW = gon_cnt_w(DEPTH);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  ready;
  logic                  almost_full;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_ready;
  logic [CW-1:0]         count;
  logic                  overflow;

  modport master (
    output wr_en, wr_data, rd_ready,
    input  ready, almost_full, rd_valid, rd_data, count, overflow
  );

  modport slave (
    input  wr_en, wr_data, rd_ready,
    output ready, almost_full, rd_valid, rd_data, count, overflow
  );

endinterface : gon_pe_fifo_if

// File: rtl/gon_fifo_mem.sv
// DEPTH x DATA_WIDTH register array: one synchronous write port, one async read port, no reset.
module gon_fifo_mem #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4
) (
  input  logic                         link_clk,
  input  logic                         we_i,
  input  logic [$clog2(DEPTH)-1:0]     waddr_i,
  input  logic [DATA_WIDTH-1:0]        wdata_i,
  input  logic [$clog2(DEPTH)-1:0]     raddr_i,
  output logic [DATA_WIDTH-1:0]        rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge link_clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : gon_fifo_mem

// File: rtl/gon_pe_fifo.sv
// Per-PE FWFT receive FIFO behind the GON multicast controller.
// Optional high-water-mark output under GON_PE_FIFO_STATS_EN.
module gon_pe_fifo
  import gon_pkg::*;
#(
  parameter int DATA_WIDTH = GON_DATA_WIDTH,
  parameter int DEPTH      = 4,
  parameter int AF_LEVEL   = DEPTH - 1
) (
  input  logic                 link_clk,
  input  logic                 reset,
  gon_pe_fifo_if.slave         bus
`ifdef GON_PE_FIFO_STATS_EN
  ,
  output logic [$clog2(DEPTH):0] hwm
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = gon_cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  full, empty;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] head;

  assign full   = (count_q == FULL_CNT);
  assign empty  = (count_q == '0);
  assign wr_acc = bus.wr_en & ~full;
  assign rd_acc = bus.rd_ready & ~empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (bus.wr_en & full);
    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge link_clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  gon_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .link_clk (link_clk),
    .we_i     (wr_acc),
    .waddr_i  (wr_ptr_q),
    .wdata_i  (bus.wr_data),
    .raddr_i  (rd_ptr_q),
    .rdata_o  (head)
  );

  // Zero the head while empty so unwritten storage never reaches the PE.
  assign bus.rd_data     = empty ? '0 : head;
  assign bus.rd_valid    = ~empty;
  assign bus.ready       = ~full;
  assign bus.almost_full = (count_q >= AF_CNT);
  assign bus.count       = count_q;
  assign bus.overflow    = overflow_q;

`ifdef GON_PE_FIFO_STATS_EN
  logic [CW-1:0] hwm_q, hwm_d;

  always_comb begin
    hwm_d = hwm_q;
    if (count_q > hwm_q) hwm_d = count_q;
  end

  always_ff @(posedge link_clk or negedge reset) begin
    if (!reset) hwm_q <= '0;
    else        hwm_q <= hwm_d;
  end

  assign hwm = hwm_q;
`endif

endmodule : gon_pe_fifo

// File: tb/tb_gon_pe_fifo.sv
// Directed bench for gon_pe_fifo with a queue scoreboard on the read side.
module tb_gon_pe_fifo;

  localparam int DW    = 64;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_pass  = 0;
  int   n_total = 0;
  int   m_cnt   = 0;
  bit   m_ovf   = 0;
  logic [DW-1:0] sb[$];

  always #5 clk = ~clk;

  gon_pe_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

`ifdef GON_PE_FIFO_STATS_EN
  logic [2:0] hwm;
`endif

  gon_pe_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .link_clk (clk),
    .reset    (rst_n),
    .bus      (bus)
`ifdef GON_PE_FIFO_STATS_EN
    ,
    .hwm      (hwm)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock: drive at negedge, score any read, let the edge happen, sample 1ns later.
  task automatic cyc(input logic we, input logic [63:0] d, input logic re);
    bit wacc, racc;
    @(negedge clk);
    bus.wr_en    = we;
    bus.wr_data  = we ? d : 'z;
    bus.rd_ready = re;
    #1;
    racc = re && (m_cnt != 0);
    wacc = we && (m_cnt < DEPTH);
    if (we && m_cnt == DEPTH) m_ovf = 1;
    if (racc) chk("rd_data", bus.rd_data, sb.pop_front());
    if (wacc) sb.push_back(d);
    m_cnt = m_cnt + int'(wacc) - int'(racc);
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".count"},    64'(bus.count),       64'(m_cnt));
    chk({tag, ".ready"},    64'(bus.ready),       64'(m_cnt != DEPTH));
    chk({tag, ".rd_valid"}, 64'(bus.rd_valid),    64'(m_cnt != 0));
    chk({tag, ".af"},       64'(bus.almost_full), 64'(m_cnt >= DEPTH - 1));
    chk({tag, ".ovf"},      64'(bus.overflow),    64'(m_ovf));
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_data  = 'z;
    bus.rd_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 0);
    cyc(0, 0, 0);

    // Reset then idle with the data bus floating
    chk("rst.count",    64'(bus.count),    64'd0);
    chk("rst.ready",    64'(bus.ready),    64'd1);
    chk("rst.rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("rst.overflow", 64'(bus.overflow), 64'd0);
    chk("rst.rd_known", 64'($isunknown(bus.rd_data)), 64'd0);

    // Fill to full
    cyc(1, 64'h11, 0); check_state("w1");
    cyc(1, 64'h22, 0); check_state("w2");
    cyc(1, 64'h33, 0); check_state("w3");
    chk("w3.af_on", 64'(bus.almost_full), 64'd1);
    cyc(1, 64'h44, 0); check_state("w4");
    chk("full.ready", 64'(bus.ready), 64'd0);
    chk("full.head",  bus.rd_data,    64'h11);

    // Write while full: dropped, overflow sticky
    cyc(1, 64'h55, 0); check_state("ovf1");
    chk("ovf.set", 64'(bus.overflow), 64'd1);
    cyc(1, 64'h55, 0); check_state("ovf2");
    chk("ovf.head", bus.rd_data, 64'h11);

    // Drain: only the four original words come out
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1);
      check_state("drain");
    end
    chk("drain.rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("drain.ovf_held", 64'(bus.overflow), 64'd1);
    cyc(0, 0, 1); check_state("drain_empty");

    // Streaming at count=1 across pointer wrap
    cyc(1, 64'h100, 0); check_state("s0");
    for (int i = 1; i <= 10; i++) begin
      cyc(1, 64'h100 + 64'(i), 1);
      chk("stream.count", 64'(bus.count), 64'd1);
    end
    chk("stream.head", bus.rd_data, 64'h10A);
    cyc(0, 0, 1); check_state("s_end");

    // Reset mid-burst at count=3
    cyc(1, 64'hA1, 0);
    cyc(1, 64'hA2, 0);
    cyc(1, 64'hA3, 0); check_state("pre_rst");
    @(negedge clk);
    bus.wr_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    m_cnt = 0; m_ovf = 0; sb.delete();
    chk("arst.count",    64'(bus.count),    64'd0);
    chk("arst.rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("arst.ready",    64'(bus.ready),    64'd1);
    chk("arst.ovf",      64'(bus.overflow), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 64'hAA, 0); check_state("post_rst");
    chk("post_rst.head", bus.rd_data, 64'hAA);
    cyc(0, 0, 1); check_state("post_rst_rd");

`ifdef GON_PE_FIFO_STATS_EN
    cyc(1, 64'h1, 0); cyc(1, 64'h2, 0); cyc(1, 64'h3, 0);
    cyc(0, 0, 1); cyc(0, 0, 1); cyc(0, 0, 1);
    cyc(1, 64'h4, 0); cyc(1, 64'h5, 0);
    cyc(0, 0, 0);
    chk("hwm.peak", 64'(hwm), 64'd3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_cnt = 0; m_ovf = 0; sb.delete();
    chk("hwm.reset", 64'(hwm), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_gon_pe_fifo
